// File: rtl/dot_seq_if.sv
// Bundles the load, run, MAC and result signals of the dot-product operand sequencer.
// The slave view belongs to the sequencer; the master view belongs to its surroundings.
interface dot_seq_if #(
    parameter int ELEM_W = 4,
    parameter int RES_W  = 16
);
    logic              load_valid;
    logic              load_ready;
    logic [ELEM_W-1:0] load_a;
    logic [ELEM_W-1:0] load_b;
    logic              start;
    logic              abort;
    logic              mac_clr;
    logic              mac_en;
    logic [ELEM_W-1:0] mac_a;
    logic [ELEM_W-1:0] mac_b;
    logic              mac_done;
    logic [RES_W-1:0]  mac_result;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic              err;

    modport master (
        output load_valid, load_a, load_b, start, abort, mac_done, mac_result, res_ready,
        input  load_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data, err
    );

    modport slave (
        input  load_valid, load_a, load_b, start, abort, mac_done, mac_result, res_ready,
        output load_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data, err
    );
endinterface

// File: rtl/dot_operand_sequencer.sv
// Buffers one pair of operand vectors, streams them into the dot-product MAC one pair
// per cycle, then hands the MAC result out over a valid/ready port.
module dot_operand_sequencer #(
    parameter int ELEM_W   = 4,
    parameter int NUM_ELEM = 8,
    parameter int RES_W    = 16,
    parameter int TIMEOUT  = 8
) (
    input logic     CLK,
    input logic     RESET,
    dot_seq_if.slave bus
);
    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LOAD, S_ARMED, S_CLEAR, S_STREAM, S_WAIT, S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  wp_q, wp_d;
    logic [IDX_W-1:0]  rp_q, rp_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;

    logic              load_ready_d;
    logic              mac_clr_d;
    logic              mac_en_d;
    logic [ELEM_W-1:0] mac_a_d;
    logic [ELEM_W-1:0] mac_b_d;
    logic              res_valid_d;
    logic [RES_W-1:0]  res_data_d;
    logic              err_d;

    logic [ELEM_W-1:0] buf_a [NUM_ELEM];
    logic [ELEM_W-1:0] buf_b [NUM_ELEM];

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;
        mac_clr_d   = 1'b0;
        mac_en_d    = 1'b0;
        mac_a_d     = bus.mac_a;
        mac_b_d     = bus.mac_b;
        res_valid_d = bus.res_valid;
        res_data_d  = bus.res_data;
        err_d       = 1'b0;

        if (bus.abort) begin
            // Abort beats every other event; a partly fed MAC is cleared again.
            state_d     = S_LOAD;
            wp_d        = '0;
            res_valid_d = 1'b0;
            mac_clr_d   = (state_q inside {S_CLEAR, S_STREAM, S_WAIT});
        end else begin
            if (bus.start && (state_q == S_LOAD || state_q == S_CLEAR)) begin
                err_d = 1'b1;
            end
            case (state_q)
                S_LOAD: begin
                    if (bus.load_valid && bus.load_ready) begin
                        wr_en = 1'b1;
                        if (wp_q == IDX_W'(NUM_ELEM - 1)) begin
                            wp_d    = '0;
                            state_d = S_ARMED;
                        end else begin
                            wp_d = wp_q + 1'b1;
                        end
                    end
                end
                S_ARMED: begin
                    if (bus.start) begin
                        state_d   = S_CLEAR;
                        mac_clr_d = 1'b1;
                        rp_d      = '0;
                        last_d    = 1'b0;
                    end
                end
                S_CLEAR, S_STREAM: begin
                    // The element issued at this edge is presented during the next cycle.
                    if (last_q) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d  = S_STREAM;
                        mac_en_d = 1'b1;
                        mac_a_d  = buf_a[rp_q];
                        mac_b_d  = buf_b[rp_q];
                        if (rp_q == IDX_W'(NUM_ELEM - 1)) begin
                            last_d = 1'b1;
                        end else begin
                            rp_d = rp_q + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mac_done) begin
                        res_data_d  = bus.mac_result;
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Buffer and wp are kept so the run can simply be restarted.
                        err_d     = 1'b1;
                        mac_clr_d = 1'b1;
                        state_d   = S_ARMED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_d = 1'b0;
                        wp_d        = '0;
                        state_d     = S_LOAD;
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end

        load_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= S_LOAD;
            wp_q           <= '0;
            rp_q           <= '0;
            last_q         <= 1'b0;
            cnt_q          <= '0;
            bus.load_ready <= 1'b0;
            bus.mac_clr    <= 1'b0;
            bus.mac_en     <= 1'b0;
            bus.mac_a      <= '0;
            bus.mac_b      <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
            bus.err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            wp_q           <= wp_d;
            rp_q           <= rp_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            bus.load_ready <= load_ready_d;
            bus.mac_clr    <= mac_clr_d;
            bus.mac_en     <= mac_en_d;
            bus.mac_a      <= mac_a_d;
            bus.mac_b      <= mac_b_d;
            bus.res_valid  <= res_valid_d;
            bus.res_data   <= res_data_d;
            bus.err        <= err_d;
        end
    end

    // Operand storage carries no reset; wp gates what is ever read back.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            buf_a[wp_q] <= bus.load_a;
            buf_b[wp_q] <= bus.load_b;
        end
    end
endmodule

// File: tb/tb_dot_operand_sequencer.sv
// Randomized and directed bench for dot_operand_sequencer with a behavioural MAC and
// a cycle-level reference model of the sequencer's observable outputs.
module tb_dot_operand_sequencer;
    localparam int NE   = 8;
    localparam int EW   = 4;
    localparam int RW   = 16;
    localparam int TMO  = 8;
    localparam int LAT  = NE + 2;
    localparam int M_LOAD = 0, M_ARMED = 1, M_RUN = 2, M_OUT = 3;

    logic CLK;
    logic RESET;
    dot_seq_if #(.ELEM_W(EW), .RES_W(RW)) bus ();

    dot_operand_sequencer #(.ELEM_W(EW), .NUM_ELEM(NE), .RES_W(RW), .TIMEOUT(TMO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks;
    int failures;
    int va[$];
    int vb[$];
    int en_cnt;
    bit chk_on;

    // Downstream MAC: clears on mac_clr, accumulates on mac_en, done sticks after NE enables.
    bit          mac_broken;
    logic [RW-1:0] acc;
    int          mcnt;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc          <= '0;
            mcnt         <= 0;
            bus.mac_done <= 1'b0;
        end else if (bus.mac_clr) begin
            acc          <= '0;
            mcnt         <= 0;
            bus.mac_done <= 1'b0;
        end else if (bus.mac_en) begin
            acc  <= acc + RW'(bus.mac_a) * RW'(bus.mac_b);
            mcnt <= mcnt + 1;
            if (mcnt + 1 >= NE && !mac_broken) bus.mac_done <= 1'b1;
        end
    end
    assign bus.mac_result = acc;

    // Reference model state
    int m_mode, cyc, t0, age;
    int mA[$];
    int mB[$];
    logic e_lr, e_clr, e_en, e_rv, e_err;
    int e_a, e_b;
    logic [RW-1:0] e_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_vec(input int mode);
        va.delete();
        vb.delete();
        for (int i = 0; i < NE; i++) begin
            case (mode)
                0:       begin va.push_back(i + 1); vb.push_back(2); end
                1:       begin va.push_back(15);    vb.push_back(15); end
                default: begin va.push_back(int'($urandom_range(0, 15))); vb.push_back(int'($urandom_range(0, 15))); end
            endcase
        end
    endtask

    function automatic int dot();
        int s = 0;
        for (int i = 0; i < NE; i++) s += va[i] * vb[i];
        return s % 65536;
    endfunction

    task automatic load_pairs(input int first, input int cnt, input bit gaps);
        bit ok;
        int g;
        for (int i = first; i < first + cnt; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    bus.load_valid = 1'b0;
                    bus.start      = ($urandom_range(0, 4) == 0);
                    tick();
                end
                bus.start = 1'b0;
            end
            bus.load_valid = 1'b1;
            bus.load_a     = EW'(va[i]);
            bus.load_b     = EW'(vb[i]);
            g = 0;
            do begin
                ok = bus.load_ready;
                tick();
                g++;
            end while (!ok && g < 20);
            check("load_handshake", 32'(ok), 32'd1);
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_check(input string name, input int exp);
        int n;
        do_start();
        n = 0;
        while (!bus.res_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(LAT));
        check({name, "_data"}, 32'(bus.res_data), 32'(exp));
        bus.res_ready = 1'b1;
        tick();
        check({name, "_load_ready_after"}, 32'(bus.load_ready), 32'd1);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int n;
        int accepted;
        bit saw_rv;
        checks = 0; failures = 0; en_cnt = 0; chk_on = 1'b0; mac_broken = 1'b0;
        RESET = 1'b1;
        bus.load_valid = 1'b0; bus.load_a = '0; bus.load_b = '0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.res_ready = 1'b0;
        m_mode = M_LOAD; cyc = 0; t0 = 0;
        e_lr = 0; e_clr = 0; e_en = 0; e_rv = 0; e_err = 0; e_a = 0; e_b = 0; e_rd = '0;

        fork
            // Reference model: expected outputs for the next cycle, from the rules of operation.
            forever begin
                @(posedge CLK or posedge RESET);
                if (RESET) begin
                    m_mode = M_LOAD; mA.delete(); mB.delete();
                    e_lr = 0; e_clr = 0; e_en = 0; e_rv = 0; e_err = 0; e_a = 0; e_b = 0; e_rd = '0;
                end else begin
                    age = cyc - t0;
                    e_clr = 0; e_err = 0; e_en = 0;
                    if (bus.abort) begin
                        if (m_mode == M_RUN) e_clr = 1;
                        m_mode = M_LOAD; mA.delete(); mB.delete(); e_rv = 0;
                    end else begin
                        case (m_mode)
                            M_LOAD: begin
                                if (bus.start) e_err = 1;
                                if (bus.load_valid && e_lr) begin
                                    mA.push_back(int'(bus.load_a));
                                    mB.push_back(int'(bus.load_b));
                                    if (mA.size() == NE) m_mode = M_ARMED;
                                end
                            end
                            M_ARMED: if (bus.start) begin
                                m_mode = M_RUN; t0 = cyc; e_clr = 1;
                            end
                            M_RUN: begin
                                if (age == 1 && bus.start) e_err = 1;
                                if (age >= 1 && age <= NE) begin
                                    e_en = 1; e_a = mA[age - 1]; e_b = mB[age - 1];
                                end
                                if (age >= NE + 2) begin
                                    if (bus.mac_done) begin
                                        m_mode = M_OUT; e_rv = 1; e_rd = bus.mac_result;
                                    end else if (age == NE + 2 + TMO - 1) begin
                                        e_err = 1; e_clr = 1; m_mode = M_ARMED;
                                    end
                                end
                            end
                            default: if (bus.res_ready) begin
                                e_rv = 0; m_mode = M_LOAD; mA.delete(); mB.delete();
                            end
                        endcase
                    end
                    e_lr = (m_mode == M_LOAD);
                    cyc++;
                end
            end
            // Per-cycle comparison against the model, away from the active edge.
            forever begin
                @(negedge CLK);
                if (!RESET && chk_on) begin
                    if (bus.mac_en) en_cnt++;
                    check("load_ready", 32'(bus.load_ready), 32'(e_lr));
                    check("mac_clr", 32'(bus.mac_clr), 32'(e_clr));
                    check("mac_en", 32'(bus.mac_en), 32'(e_en));
                    check("err", 32'(bus.err), 32'(e_err));
                    check("res_valid", 32'(bus.res_valid), 32'(e_rv));
                    if (e_en) begin
                        check("mac_a", 32'(bus.mac_a), 32'(e_a));
                        check("mac_b", 32'(bus.mac_b), 32'(e_b));
                    end
                    if (e_rv) check("res_data", 32'(bus.res_data), 32'(e_rd));
                end
            end
            begin
                #500000;
                $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
                $fatal(1, "watchdog expired");
            end
        join_none

        tick();
        tick();
        check("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("rst_mac_clr", 32'(bus.mac_clr), 32'd0);
        check("rst_mac_en", 32'(bus.mac_en), 32'd0);
        check("rst_mac_a", 32'(bus.mac_a), 32'd0);
        check("rst_mac_b", 32'(bus.mac_b), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        RESET = 1'b0;
        chk_on = 1'b1;
        tick();
        check("load_ready_after_reset", 32'(bus.load_ready), 32'd1);

        // Ramp: 1..8 times 2
        set_vec(0);
        load_pairs(0, NE, 1'b0);
        check("ramp_armed", 32'(bus.load_ready), 32'd0);
        bus.res_ready = 1'b1;
        en_cnt = 0;
        run_check("ramp", 16'h0048);
        check("ramp_en_cycles", 32'(en_cnt), 32'd8);
        check("ramp_model_dot", 32'(dot()), 32'h48);

        // Saturating operands, twice back to back
        set_vec(1);
        load_pairs(0, NE, 1'b0);
        run_check("sat1", 16'h0708);
        load_pairs(0, NE, 1'b0);
        run_check("sat2", 16'h0708);

        // Backpressure on the result port
        set_vec(2);
        load_pairs(0, NE, 1'b0);
        do_start();
        n = 0;
        while (!bus.res_valid && n < 40) begin tick(); n++; end
        check("bp_latency", 32'(n), 32'(LAT));
        for (int i = 0; i < 5; i++) begin
            check("bp_res_data", 32'(bus.res_data), 32'(dot()));
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_load_ready", 32'(bus.load_ready), 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_load_ready_after", 32'(bus.load_ready), 32'd1);
        check("bp_res_valid_after", 32'(bus.res_valid), 32'd0);

        // Early start after five pairs
        set_vec(2);
        load_pairs(0, 5, 1'b0);
        do_start();
        check("early_err", 32'(bus.err), 32'd1);
        check("early_no_en", 32'(bus.mac_en), 32'd0);
        check("early_still_load", 32'(bus.load_ready), 32'd1);
        tick();
        check("early_err_once", 32'(bus.err), 32'd0);
        load_pairs(5, 3, 1'b0);
        check("early_armed", 32'(bus.load_ready), 32'd0);
        run_check("early_run", dot());

        // Abort on the fourth enable cycle
        set_vec(2);
        load_pairs(0, NE, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) tick();
        check("abort_in_stream", 32'(bus.mac_en), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_mac_en", 32'(bus.mac_en), 32'd0);
        check("abort_mac_clr", 32'(bus.mac_clr), 32'd1);
        check("abort_load_ready", 32'(bus.load_ready), 32'd1);
        saw_rv = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.res_valid) saw_rv = 1'b1;
            tick();
        end
        check("abort_no_res_valid", 32'(saw_rv), 32'd0);
        set_vec(2);
        load_pairs(0, NE, 1'b0);
        run_check("after_abort", dot());

        // Timeout with a silent MAC, then retry from the kept buffer
        set_vec(2);
        load_pairs(0, NE, 1'b0);
        mac_broken = 1'b1;
        do_start();
        n = 0;
        while (!bus.err && n < 40) begin tick(); n++; end
        check("timeout_latency", 32'(n), 32'(NE + 1 + TMO));
        check("timeout_mac_clr", 32'(bus.mac_clr), 32'd1);
        mac_broken = 1'b0;
        tick();
        check("timeout_armed", 32'(bus.load_ready), 32'd0);
        run_check("retry", dot());

        // Randomized runs with load gaps, stray starts and random result backpressure
        for (int r = 0; r < 20; r++) begin
            set_vec(2);
            load_pairs(0, NE, 1'b1);
            do_start();
            n = 0;
            while (!bus.res_valid && n < 40) begin tick(); n++; end
            check("rnd_latency", 32'(n), 32'(LAT));
            check("rnd_data", 32'(bus.res_data), 32'(dot()));
            accepted = 0;
            n = 0;
            while (!accepted && n < 60) begin
                bus.res_ready = 1'($urandom_range(0, 1));
                accepted = int'(bus.res_ready && bus.res_valid);
                tick();
                n++;
            end
            bus.res_ready = 1'b0;
            check("rnd_accepted", 32'(accepted), 32'd1);
        end

        // Asynchronous reset in the middle of a stream
        set_vec(2);
        load_pairs(0, NE, 1'b0);
        do_start();
        tick();
        tick();
        RESET = 1'b1;
        #1;
        check("async_rst_mac_en", 32'(bus.mac_en), 32'd0);
        check("async_rst_mac_a", 32'(bus.mac_a), 32'd0);
        check("async_rst_load_ready", 32'(bus.load_ready), 32'd0);
        check("async_rst_res_valid", 32'(bus.res_valid), 32'd0);
        tick();
        RESET = 1'b0;
        tick();
        check("async_rst_recover", 32'(bus.load_ready), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dot_operand_sequencer.md
# dot_operand_sequencer

Buffers one pair of NUM_ELEM-element operand vectors, loaded over a valid/ready port, then streams them one pair per cycle into the downstream dot-product MAC stage. It clears the MAC before each run, waits for the MAC's done flag, and returns the 16-bit result over a valid/ready output port. It sits directly upstream of the dot-product MAC and owns its control signals: clear, enable, operands, done and result.

## Interface
- ELEM_W, 4, operand element width
- NUM_ELEM, 8, elements per vector; must equal the MAC's element count
- RES_W, 16, result width
- TIMEOUT, 8, cycles to wait in WAIT for mac_done before flagging an error
- CLK  in  1  clock; all state changes on the rising edge
- RESET  in  1  reset, asynchronous, active-high
- load_valid  in  1  operand pair present on load_a/load_b
- load_ready  out  1  buffer accepts a pair; high only in LOAD
- load_a, load_b  in  ELEM_W  element of vector A and element of vector B
- start  in  1  request a run; honoured only in ARMED
- abort  in  1  cancel any load or run; return to LOAD with an empty buffer
- mac_clr  out  1  one-cycle pulse wired to the MAC stage's reset
- mac_en  out  1  MAC enable, high for exactly NUM_ELEM consecutive cycles per run
- mac_a, mac_b  out  ELEM_W  registered operands, aligned with mac_en
- mac_done  in  1  MAC done flag
- mac_result  in  RES_W  MAC accumulated result
- res_valid  out  1  result available on res_data
- res_ready  in  1  consumer accepts the result
- res_data  out  RES_W  captured result, held stable while res_valid is high
- err  out  1  one-cycle pulse: timeout, or start outside ARMED

## Operation
- States: LOAD, ARMED, CLEAR, STREAM, WAIT, OUT.
- Buffer: two NUM_ELEM x ELEM_W register arrays, a write pointer (wp) and a read pointer (rp).
- LOAD: load_ready=1. A pair is accepted when load_valid & load_ready. The accepted pair is written at wp and wp increments. When the NUM_ELEMth pair is accepted, the FSM goes to ARMED and load_ready drops on the next cycle.
- ARMED: start=1 goes to CLEAR.
- start outside ARMED is ignored and pulses err, except during STREAM, WAIT and OUT, where it is ignored silently.
- CLEAR: mac_clr=1 for exactly one cycle; rp is set to 0; then STREAM.
- STREAM: mac_en=1, mac_a=A[rp], mac_b=B[rp], rp increments every cycle. After rp = NUM_ELEM-1 is issued, the FSM goes to WAIT and mac_en=0 on the next cycle.
- WAIT: a timeout counter runs.
  - mac_done=1: mac_result is captured into res_data, then OUT.
  - Counter reaches TIMEOUT: err pulses, mac_clr pulses, the FSM returns to ARMED, and the buffer is kept so the run can be retried.
- OUT: res_valid=1 until res_valid & res_ready. Then wp is cleared and the FSM returns to LOAD. The buffer contents are stale; they are simply overwritten by the next load.
- abort has priority over every other event in every state:
  - next state is LOAD and wp is cleared
  - mac_en=0 next cycle
  - mac_clr pulses one cycle if the FSM was in CLEAR, STREAM or WAIT
  - res_valid drops and any result in OUT is discarded
- Simultaneous load_valid and abort in LOAD: the pair is not written.
- mac_done seen outside WAIT is ignored.
- Arithmetic: none locally. The result width is set by the MAC, and res_data is a pure capture.

## Timing
- Reset values: all of the following are 0, and the state is LOAD.
  - load_ready=0 while RESET is asserted, then 1 from the first cycle after RESET deasserts
  - mac_clr, mac_en, mac_a, mac_b, res_valid, res_data, err, wp, rp
- All outputs are registered.
- Latency, start sampled at edge k:
  - cycle k+1: CLEAR
  - cycles k+2 .. k+NUM_ELEM+1: STREAM
  - cycle k+NUM_ELEM+2: first WAIT cycle; the MAC's done flag, registered at the last enable edge, is high here
  - edge ending cycle k+NUM_ELEM+2: result captured
  - cycle k+NUM_ELEM+3 (k+11 for the defaults): res_valid=1
- Load throughput: one pair per cycle. The minimum load-to-ARMED time is NUM_ELEM cycles.
- Output handshake: res_data holds while res_valid & !res_ready. The earliest next load_ready is the cycle after the accepting edge.
- Timeout: err pulses TIMEOUT cycles after WAIT is entered if mac_done stays low.
- RESET asserted mid-run: all outputs go to their reset values immediately (asynchronous).

## Test plan
- Ramp: A=1..8, B=2 for every element, then start with res_ready=1 -> mac_en high for 8 cycles, res_data=0x0048, res_valid 11 cycles after start.
- Saturating operands: A=B=15 for every element -> res_data=0x0708. Run twice back to back; both runs return 0x0708, which proves mac_clr clears the accumulator.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data stable and load_ready=0 throughout; load_ready=1 the cycle after acceptance.
- Early start: start after only 5 pairs loaded -> err pulses once, no mac_en, still in LOAD; loading 3 more pairs then reaches ARMED.
- Abort mid-STREAM: abort on the 4th mac_en cycle -> mac_en=0 and mac_clr=1 the next cycle, no res_valid, wp=0, load_ready=1.
- Timeout: mac_done tied to 0 -> err pulses 8 cycles after WAIT is entered, FSM returns to ARMED; a retry with a working MAC returns the correct result.
